// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares the single-port 16x8 DFF RAM between port 0 (CPU) and port 1
//   (host loader/debug). It arbitrates between the two, then sequences the
//   RAM MAR / ce_n / lr_n strobes for the winner. Read data comes from the
//   RAM's registered output and is returned to the owning port.
//
//   Ports
//     clk, rst                      clock, synchronous active-high reset
//     pN_req_valid/we/addr/wdata    request from port N (held until ready)
//     pN_req_ready                  combinational accept (IDLE, granted, valid)
//     pN_rsp_valid                  one-cycle completion pulse
//     pN_rsp_rdata                  read data, held until next read on port N
//     ram_mar/ram_data_in           registered RAM address / write data
//     ram_ce_n/ram_lr_n             registered active-low read / write strobes
//     ram_data_out                  registered read data from the RAM
//
//   Configuration
//     RAM_ARB_ROUND_ROBIN_EN  defined: on contention grant the port opposite
//                             the last grant. Undefined: port 0 always wins.
module ram_port_arbiter #(
  parameter int ADDR_BITS = 4,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p0_req_valid,
  input  logic                 p0_req_we,
  input  logic [ADDR_BITS-1:0] p0_req_addr,
  input  logic [DATA_BITS-1:0] p0_req_wdata,
  output logic                 p0_req_ready,
  output logic                 p0_rsp_valid,
  output logic [DATA_BITS-1:0] p0_rsp_rdata,
  input  logic                 p1_req_valid,
  input  logic                 p1_req_we,
  input  logic [ADDR_BITS-1:0] p1_req_addr,
  input  logic [DATA_BITS-1:0] p1_req_wdata,
  output logic                 p1_req_ready,
  output logic                 p1_rsp_valid,
  output logic [DATA_BITS-1:0] p1_rsp_rdata,
  output logic [ADDR_BITS-1:0] ram_mar,
  output logic [DATA_BITS-1:0] ram_data_in,
  output logic                 ram_ce_n,
  output logic                 ram_lr_n,
  input  logic [DATA_BITS-1:0] ram_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  state_t state, state_nxt;

  logic                 grant;   // 0: port 0 wins, 1: port 1 wins
  logic                 accept;
  logic                 owner;
  logic                 own_we;
  logic                 sel_we;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [DATA_BITS-1:0] sel_wdata;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic last_grant;

  always_comb begin
    grant = ~p0_req_valid;
    if (p0_req_valid && p1_req_valid) grant = ~last_grant;
  end

  always_ff @(posedge clk) begin
    if (rst)         last_grant <= 1'b1;
    else if (accept) last_grant <= grant;
  end
`else
  // Fixed priority: port 1 only wins when port 0 is not asking.
  assign grant = ~p0_req_valid;
`endif

  assign p0_req_ready = (state == IDLE) && p0_req_valid && !grant;
  assign p1_req_ready = (state == IDLE) && p1_req_valid &&  grant;
  assign accept       = p0_req_ready || p1_req_ready;

  assign sel_we    = grant ? p1_req_we    : p0_req_we;
  assign sel_addr  = grant ? p1_req_addr  : p0_req_addr;
  assign sel_wdata = grant ? p1_req_wdata : p0_req_wdata;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS:  state_nxt = own_we ? RESP : CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered RAM interface and responses. The strobes are loaded on the
  // accept edge so they are visible during ACCESS and fall back to idle on
  // the following edge, giving exactly one active cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner        <= 1'b0;
      own_we       <= 1'b0;
      ram_mar      <= '0;
      ram_data_in  <= '0;
      ram_ce_n     <= 1'b1;
      ram_lr_n     <= 1'b1;
      p0_rsp_valid <= 1'b0;
      p1_rsp_valid <= 1'b0;
      p0_rsp_rdata <= '0;
      p1_rsp_rdata <= '0;
    end else begin
      ram_ce_n     <= 1'b1;
      ram_lr_n     <= 1'b1;
      p0_rsp_valid <= 1'b0;
      p1_rsp_valid <= 1'b0;
      if (accept) begin
        owner   <= grant;
        own_we  <= sel_we;
        ram_mar <= sel_addr;
        if (sel_we) begin
          ram_lr_n    <= 1'b0;
          ram_data_in <= sel_wdata;
        end else begin
          ram_ce_n    <= 1'b0;
        end
      end
      // RAM output registered the read during ACCESS; it is valid in CAPTURE.
      if (state == CAPTURE) begin
        if (owner) p1_rsp_rdata <= ram_data_out;
        else       p0_rsp_rdata <= ram_data_out;
      end
      if (state_nxt == RESP) begin
        if (owner) p1_rsp_valid <= 1'b1;
        else       p0_rsp_valid <= 1'b1;
      end
    end
  end

endmodule
